// File: rtl/axilite_reg_pkg.sv
// Shared definitions for the AXI4-Lite control/status register slave:
// response codes, register offsets, decode selects and FSM encodings.
package axilite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned OFF_CTRL    = 32'h00;
  localparam int unsigned OFF_STATUS  = 32'h04;
  localparam int unsigned OFF_COUNT   = 32'h08;
  localparam int unsigned OFF_ISR     = 32'h0C;
  localparam int unsigned OFF_IER     = 32'h10;
  localparam int unsigned OFF_SCRATCH = 32'h20;

  // CTRL[1] is a write-1 strobe that clears COUNT and is never stored.
  localparam logic [31:0] CTRL_SELFCLR_MASK = 32'h0000_0002;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_COUNT,
    SEL_ISR,
    SEL_IER,
    SEL_SCRATCH
  } regSelT;

  typedef enum logic [2:0] {
    W_RESET,
    W_IDLE,
    W_WAIT_D,
    W_WAIT_A,
    W_RESP
  } wrStateT;

  typedef enum logic [1:0] {
    R_RESET,
    R_IDLE,
    R_DATA
  } rdStateT;

  // Expands the four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] strbMask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axilite_reg_decode.sv
// Combinational address decoder shared by the read and write paths.
// The low two address bits are ignored; anything off the map is DECERR.
module axilite_reg_decode
  import axilite_reg_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_SCRATCH = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  output regSelT            sel_o,
  output logic [2:0]        scratchIdx_o,
  output logic              decerr_o
);

  localparam int unsigned SCRATCH_END = OFF_SCRATCH + 4 * unsigned'(NUM_SCRATCH);

  logic [ADDR_W-1:0] wordAddr;

  assign wordAddr = addr_i & ~ADDR_W'(3);

  // Map the word address onto a register select and scratch index.
  always_comb begin
    sel_o        = SEL_NONE;
    scratchIdx_o = 3'd0;
    if (wordAddr == ADDR_W'(OFF_CTRL)) begin
      sel_o = SEL_CTRL;
    end else if (wordAddr == ADDR_W'(OFF_STATUS)) begin
      sel_o = SEL_STATUS;
    end else if (wordAddr == ADDR_W'(OFF_COUNT)) begin
      sel_o = SEL_COUNT;
    end else if (wordAddr == ADDR_W'(OFF_ISR)) begin
      sel_o = SEL_ISR;
    end else if (wordAddr == ADDR_W'(OFF_IER)) begin
      sel_o = SEL_IER;
    end else if ((wordAddr >= ADDR_W'(OFF_SCRATCH)) && (wordAddr < ADDR_W'(SCRATCH_END))) begin
      sel_o        = SEL_SCRATCH;
      scratchIdx_o = wordAddr[4:2];
    end
  end

  assign decerr_o = (sel_o == SEL_NONE);

endmodule

// File: rtl/axilite_reg_slave.sv
// AXI4-Lite register slave: CTRL, live STATUS, cycle COUNT, sticky ISR
// with IER mask and a small bank of scratch words. AW and W are accepted
// independently; reads are answered from a registered R channel.
module axilite_reg_slave
  import axilite_reg_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_SCRATCH = 4,
  parameter int IRQ_W       = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic [31:0]       ctrl_out,
  input  logic [31:0]       status_in,
  input  logic [IRQ_W-1:0]  irq_in,
  output logic              irq_out
);

  wrStateT           wState_q, wState_d;
  rdStateT           rState_q, rState_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       ctrl_q, ctrl_d;
  logic [31:0]       count_q, count_d;
  logic [IRQ_W-1:0]  isr_q, isr_d;
  logic [IRQ_W-1:0]  ier_q, ier_d;
  logic [31:0]       scratch_q [NUM_SCRATCH];
  logic [31:0]       scratch_d [NUM_SCRATCH];
  logic              irq_q;

  logic              commit;
  logic [ADDR_W-1:0] cAddr;
  logic [31:0]       cData;
  logic [3:0]        cStrb;
  logic [31:0]       wMask;
  logic              wrEn;
  logic              countClr;
  logic [IRQ_W-1:0]  isrClr;
  logic [31:0]       rdMux;

  regSelT            wSel, rSel;
  logic [2:0]        wScrIdx, rScrIdx;
  logic              wDecerr, rDecerr;

  axilite_reg_decode #(.ADDR_W(ADDR_W), .NUM_SCRATCH(NUM_SCRATCH)) uWrDecode (
    .addr_i       (cAddr),
    .sel_o        (wSel),
    .scratchIdx_o (wScrIdx),
    .decerr_o     (wDecerr)
  );

  axilite_reg_decode #(.ADDR_W(ADDR_W), .NUM_SCRATCH(NUM_SCRATCH)) uRdDecode (
    .addr_i       (s_axi_araddr),
    .sel_o        (rSel),
    .scratchIdx_o (rScrIdx),
    .decerr_o     (rDecerr)
  );

  // Write FSM: collect AW and W in either order, commit on the last one.
  always_comb begin
    wState_d = wState_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    commit   = 1'b0;
    cAddr    = awaddr_q;
    cData    = wdata_q;
    cStrb    = wstrb_q;
    case (wState_q)
      W_RESET: wState_d = W_IDLE;
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid) begin
          commit   = 1'b1;
          cAddr    = s_axi_awaddr;
          cData    = s_axi_wdata;
          cStrb    = s_axi_wstrb;
          wState_d = W_RESP;
        end else if (s_axi_awvalid) begin
          awaddr_d = s_axi_awaddr;
          wState_d = W_WAIT_D;
        end else if (s_axi_wvalid) begin
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
          wState_d = W_WAIT_A;
        end
      end
      W_WAIT_D: begin
        if (s_axi_wvalid) begin
          commit   = 1'b1;
          cData    = s_axi_wdata;
          cStrb    = s_axi_wstrb;
          wState_d = W_RESP;
        end
      end
      W_WAIT_A: begin
        if (s_axi_awvalid) begin
          commit   = 1'b1;
          cAddr    = s_axi_awaddr;
          wState_d = W_RESP;
        end
      end
      W_RESP: if (s_axi_bready) wState_d = W_IDLE;
      default: wState_d = W_RESET;
    endcase
    if (commit) bresp_d = wDecerr ? RESP_DECERR : RESP_OKAY;
  end

  assign wMask = strbMask(cStrb);
  assign wrEn  = commit && !wDecerr;

  // Register bank next state: byte-masked writes, W1C ISR, COUNT clear/run.
  always_comb begin
    ctrl_d    = ctrl_q;
    ier_d     = ier_q;
    scratch_d = scratch_q;
    isrClr    = '0;
    countClr  = 1'b0;
    if (wrEn) begin
      case (wSel)
        SEL_CTRL: begin
          ctrl_d   = ((ctrl_q & ~wMask) | (cData & wMask)) & ~CTRL_SELFCLR_MASK;
          countClr = cStrb[0] & cData[1];
        end
        SEL_ISR: isrClr = IRQ_W'(cData & wMask);
        SEL_IER: ier_d  = IRQ_W'((32'(ier_q) & ~wMask) | (cData & wMask));
        SEL_SCRATCH: begin
          for (int n = 0; n < NUM_SCRATCH; n++) begin
            if (wScrIdx == 3'(n)) scratch_d[n] = (scratch_q[n] & ~wMask) | (cData & wMask);
          end
        end
        default: ;
      endcase
    end
    if (countClr) begin
      count_d = '0;
    end else if (ctrl_q[0]) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    isr_d = (isr_q & ~isrClr) | irq_in;
  end

  // Read data mux, evaluated from pre-edge register values.
  always_comb begin
    rdMux = '0;
    case (rSel)
      SEL_CTRL:   rdMux = ctrl_q;
      SEL_STATUS: rdMux = status_in;
      SEL_COUNT:  rdMux = count_q;
      SEL_ISR:    rdMux = 32'(isr_q);
      SEL_IER:    rdMux = 32'(ier_q);
      SEL_SCRATCH: begin
        for (int n = 0; n < NUM_SCRATCH; n++) begin
          if (rScrIdx == 3'(n)) rdMux = scratch_q[n];
        end
      end
      default: rdMux = '0;
    endcase
  end

  // Read FSM: capture data and response on the AR handshake, hold until rready.
  always_comb begin
    rState_d = rState_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rState_q)
      R_RESET: rState_d = R_IDLE;
      R_IDLE: begin
        if (s_axi_arvalid) begin
          rdata_d  = rdMux;
          rresp_d  = rDecerr ? RESP_DECERR : RESP_OKAY;
          rState_d = R_DATA;
        end
      end
      R_DATA: if (s_axi_rready) rState_d = R_IDLE;
      default: rState_d = R_RESET;
    endcase
  end

  // State and register flops; reset drops both FSMs back to their RESET state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wState_q  <= W_RESET;
      rState_q  <= R_RESET;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ctrl_q    <= '0;
      count_q   <= '0;
      isr_q     <= '0;
      ier_q     <= '0;
      scratch_q <= '{default: '0};
      irq_q     <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      rState_q  <= rState_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      isr_q     <= isr_d;
      ier_q     <= ier_d;
      scratch_q <= scratch_d;
      irq_q     <= |(isr_q & ier_q);
    end
  end

  assign s_axi_awready = (wState_q == W_IDLE) || (wState_q == W_WAIT_A);
  assign s_axi_wready  = (wState_q == W_IDLE) || (wState_q == W_WAIT_D);
  assign s_axi_bvalid  = (wState_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = (rState_q == R_IDLE);
  assign s_axi_rvalid  = (rState_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign irq_out       = irq_q;

endmodule

// File: tb/tb_axilite_reg_slave.sv
// Scoreboard bench for axilite_reg_slave. Drivers push the expected B/R
// response into queues; a negedge monitor pops and compares whenever a
// response handshake is about to complete.
module tb_axilite_reg_slave;

  localparam int ADDR_W  = 16;
  localparam int IRQ_W   = 8;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rExpT;

  logic              clk;
  logic              resetn;
  logic              s_axi_awvalid, s_axi_awready;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_wvalid, s_axi_wready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_bvalid, s_axi_bready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_arvalid, s_axi_arready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_rvalid, s_axi_rready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic [31:0]       ctrl_out;
  logic [31:0]       status_in;
  logic [IRQ_W-1:0]  irq_in;
  logic              irq_out;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lastCommitEdge = 0;
  int          countBase = 0;
  bit          countRunning = 0;
  logic [1:0]  bQ[$];
  rExpT        rQ[$];

  axilite_reg_slave #(.ADDR_W(ADDR_W), .NUM_SCRATCH(4), .IRQ_W(IRQ_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .ctrl_out      (ctrl_out),
    .status_in     (status_in),
    .irq_in        (irq_in),
    .irq_out       (irq_out)
  );

  // Free-running clock and edge counter used to predict COUNT reads.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges beyond the per-handshake bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic readyOf(input int which);
    case (which)
      0:       return s_axi_awready;
      1:       return s_axi_wready;
      2:       return s_axi_bvalid;
      3:       return s_axi_arready;
      default: return s_axi_rvalid;
    endcase
  endfunction

  // Waits (bounded) for a handshake; returns with time at posedge+1 of that edge.
  task automatic waitReady(input int which, input string name, output int edgeNum);
    bit ok = 1'b0;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(negedge clk);
      if (readyOf(which)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    edgeNum = cyc;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: no handshake after %0d cycles, expected within %0d", name, TIMEOUT, TIMEOUT);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One write or read transaction; expected response goes into the scoreboard.
  task automatic applyStimulus(input bit isWrite, input logic [15:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awLead, input int wLead,
                               input int respDelay, input logic [31:0] expData, input logic [1:0] expResp);
    int   awE, wE, arE, hsE;
    rExpT re;
    if (isWrite) begin
      bQ.push_back(expResp);
      fork
        begin
          idle(awLead);
          s_axi_awaddr  = addr;
          s_axi_awvalid = 1'b1;
          waitReady(0, "aw_handshake", awE);
          s_axi_awvalid = 1'b0;
        end
        begin
          idle(wLead);
          s_axi_wdata  = data;
          s_axi_wstrb  = strb;
          s_axi_wvalid = 1'b1;
          waitReady(1, "w_handshake", wE);
          s_axi_wvalid = 1'b0;
        end
      join
      lastCommitEdge = (awE > wE) ? awE : wE;
      repeat (respDelay) begin
        @(negedge clk);
        checkOutput("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
        checkOutput("b_hold_resp", 32'(s_axi_bresp), 32'(expResp));
        checkOutput("b_hold_awready", 32'(s_axi_awready), 32'd0);
        checkOutput("b_hold_wready", 32'(s_axi_wready), 32'd0);
      end
      if (respDelay > 0) idle(1);
      s_axi_bready = 1'b1;
      waitReady(2, "b_handshake", hsE);
      s_axi_bready = 1'b0;
    end else begin
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      waitReady(3, "ar_handshake", arE);
      s_axi_arvalid = 1'b0;
      re.data = expData;
      if (addr == 16'h0008 && countRunning) re.data = 32'(arE - countBase - 1);
      re.resp = expResp;
      rQ.push_back(re);
      repeat (respDelay) begin
        @(negedge clk);
        checkOutput("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
        checkOutput("r_hold_data", s_axi_rdata, re.data);
        checkOutput("r_hold_resp", 32'(s_axi_rresp), 32'(re.resp));
        checkOutput("r_hold_arready", 32'(s_axi_arready), 32'd0);
      end
      if (respDelay > 0) idle(1);
      s_axi_rready = 1'b1;
      waitReady(4, "r_handshake", hsE);
      s_axi_rready = 1'b0;
    end
  endtask

  // Monitor: compare each B/R response just before its handshake edge.
  always @(negedge clk) begin : monitor
    logic [1:0] eb;
    rExpT       er;
    if (resetn && s_axi_bvalid && s_axi_bready) begin
      if (bQ.size() == 0) begin
        checkOutput("b_unexpected", 32'd1, 32'd0);
      end else begin
        eb = bQ.pop_front();
        checkOutput("bresp", 32'(s_axi_bresp), 32'(eb));
      end
    end
    if (resetn && s_axi_rvalid && s_axi_rready) begin
      if (rQ.size() == 0) begin
        checkOutput("r_unexpected", 32'd1, 32'd0);
      end else begin
        er = rQ.pop_front();
        checkOutput("rdata", s_axi_rdata, er.data);
        checkOutput("rresp", 32'(s_axi_rresp), 32'(er.resp));
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_awready"}, 32'(s_axi_awready), 32'd0);
    checkOutput({tag, "_wready"}, 32'(s_axi_wready), 32'd0);
    checkOutput({tag, "_arready"}, 32'(s_axi_arready), 32'd0);
    checkOutput({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd0);
    checkOutput({tag, "_bresp"}, 32'(s_axi_bresp), 32'd0);
    checkOutput({tag, "_rresp"}, 32'(s_axi_rresp), 32'd0);
    checkOutput({tag, "_rdata"}, s_axi_rdata, 32'd0);
    checkOutput({tag, "_ctrl_out"}, ctrl_out, 32'd0);
    checkOutput({tag, "_irq_out"}, 32'(irq_out), 32'd0);
  endtask

  task automatic releaseReset(input string tag);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_awready_reset_cycle"}, 32'(s_axi_awready), 32'd0);
    checkOutput({tag, "_arready_reset_cycle"}, 32'(s_axi_arready), 32'd0);
    idle(1);
    checkOutput({tag, "_awready_up"}, 32'(s_axi_awready), 32'd1);
    checkOutput({tag, "_wready_up"}, 32'(s_axi_wready), 32'd1);
    checkOutput({tag, "_arready_up"}, 32'(s_axi_arready), 32'd1);
  endtask

  initial begin
    resetn        = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_rready  = 1'b0;
    status_in     = 32'h1234_5678;
    irq_in        = '0;

    idle(3);
    checkResetOutputs("por");
    releaseReset("por");

    $display("[TB] scratch write/read, AW and W together");
    applyStimulus(1, 16'h0020, 32'hA5A5_1234, 4'hF, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(0, 16'h0020, 32'h0, 4'h0, 0, 0, 0, 32'hA5A5_1234, 2'b00);
    applyStimulus(0, 16'h0022, 32'h0, 4'h0, 0, 0, 0, 32'hA5A5_1234, 2'b00);

    $display("[TB] CTRL enable with W leading AW, COUNT checks");
    applyStimulus(1, 16'h0000, 32'h0000_0001, 4'h1, 2, 0, 0, 32'h0, 2'b00);
    countBase    = lastCommitEdge;
    countRunning = 1'b1;
    checkOutput("ctrl_out_enable", ctrl_out, 32'h0000_0001);
    applyStimulus(0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0001, 2'b00);
    applyStimulus(0, 16'h0008, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00);
    idle(3);
    applyStimulus(0, 16'h0008, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(1, 16'h0000, 32'h0000_0003, 4'h1, 0, 0, 0, 32'h0, 2'b00);
    countBase = lastCommitEdge;
    checkOutput("ctrl_out_selfclear", ctrl_out, 32'h0000_0001);
    applyStimulus(0, 16'h0008, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(1, 16'h0000, 32'h0000_0002, 4'h1, 0, 0, 0, 32'h0, 2'b00);
    countRunning = 1'b0;
    checkOutput("ctrl_out_disable", ctrl_out, 32'h0000_0000);
    applyStimulus(0, 16'h0008, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0000, 2'b00);

    $display("[TB] byte strobe write with AW leading W");
    applyStimulus(1, 16'h0024, 32'hFFFF_FFFF, 4'h2, 0, 2, 0, 32'h0, 2'b00);
    applyStimulus(0, 16'h0024, 32'h0, 4'h0, 0, 0, 0, 32'h0000_FF00, 2'b00);

    $display("[TB] interrupt status and mask");
    applyStimulus(1, 16'h0010, 32'h0000_0008, 4'hF, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(0, 16'h0010, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0008, 2'b00);
    checkOutput("irq_idle", 32'(irq_out), 32'd0);
    irq_in = 8'h08;
    idle(1);
    irq_in = 8'h00;
    checkOutput("irq_lag", 32'(irq_out), 32'd0);
    idle(1);
    checkOutput("irq_set", 32'(irq_out), 32'd1);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0008, 2'b00);
    applyStimulus(1, 16'h000C, 32'h0000_00FF, 4'h0, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0008, 2'b00);
    applyStimulus(1, 16'h000C, 32'h0000_0008, 4'hF, 0, 0, 0, 32'h0, 2'b00);
    checkOutput("irq_cleared", 32'(irq_out), 32'd0);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0000, 2'b00);
    irq_in = 8'h08;
    fork
      begin
        idle(1);
        irq_in = 8'h00;
      end
    join_none
    applyStimulus(1, 16'h000C, 32'h0000_0008, 4'hF, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0008, 2'b00);
    checkOutput("irq_set_wins", 32'(irq_out), 32'd1);

    $display("[TB] decode errors and read-only addresses");
    applyStimulus(0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b11);
    applyStimulus(1, 16'h0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, 2'b11);
    applyStimulus(0, 16'h0030, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b11);
    applyStimulus(0, 16'h002C, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(0, 16'h0020, 32'h0, 4'h0, 0, 0, 0, 32'hA5A5_1234, 2'b00);
    applyStimulus(1, 16'h0004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 32'h0, 2'b00);
    applyStimulus(0, 16'h0004, 32'h0, 4'h0, 0, 0, 0, 32'h1234_5678, 2'b00);

    $display("[TB] read and write to the same register on the same edge");
    fork
      applyStimulus(1, 16'h0028, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'h0, 2'b00);
      applyStimulus(0, 16'h0028, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0000, 2'b00);
    join
    applyStimulus(0, 16'h0028, 32'h0, 4'h0, 0, 0, 0, 32'hCAFE_F00D, 2'b00);

    $display("[TB] response back-pressure");
    applyStimulus(1, 16'h002C, 32'h5A5A_0F0F, 4'hF, 0, 0, 5, 32'h0, 2'b00);
    applyStimulus(0, 16'h002C, 32'h0, 4'h0, 0, 0, 5, 32'h5A5A_0F0F, 2'b00);

    $display("[TB] reset while waiting for write data");
    s_axi_awaddr  = 16'h0020;
    s_axi_awvalid = 1'b1;
    idle(1);
    s_axi_awvalid = 1'b0;
    resetn = 1'b0;
    #1;
    checkResetOutputs("midrst");
    idle(2);
    releaseReset("midrst");
    applyStimulus(0, 16'h0020, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0000, 2'b00);
    applyStimulus(0, 16'h0010, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0000, 2'b00);

    idle(2);
    checkOutput("bq_drained", 32'(bQ.size()), 32'd0);
    checkOutput("rq_drained", 32'(rQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
